// File: rtl/sisc_pkg.sv
// Shared definitions for the memory arbiter slice.
//  - state_t : arbiter FSM encoding (IDLE -> ACCESS -> DONE -> IDLE)
//  - owner_t : which requester owns the memory (OWN_IF = fetch, OWN_DM = data)
//  - other_owner() : the opposite requester, used for round-robin tie breaks
package sisc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t cur);
    owner_t res;
    if (cur == OWN_IF) begin
      res = OWN_DM;
    end else begin
      res = OWN_IF;
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational owner selection for mem_arb.
//  Inputs : if_req, dm_req (raw requests), last_owner (most recent grant)
//  Outputs: grant (any request present), owner (who gets the memory)
// Build option MEM_ARB_RR_EN:
//  - defined   : round-robin, a tie goes to the port that was not granted last
//  - undefined : fixed priority, a tie always goes to DM so the ctrl mem stage
//                never stalls behind a fetch; last_owner is ignored
module arb_pick
  import sisc_pkg::*;
(
  input  logic   if_req,
  input  logic   dm_req,
  input  owner_t last_owner,
  output logic   grant,
  output owner_t owner
);

  // Pick the owner for the next access from the live request lines
  always_comb begin
    grant = if_req | dm_req;
    owner = OWN_IF;
    if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
      owner = other_owner(last_owner);
`else
      owner = OWN_DM;
`endif
    end else if (dm_req) begin
      owner = OWN_DM;
    end else begin
      owner = OWN_IF;
    end
  end

`ifndef MEM_ARB_RR_EN
  // Fixed priority has no use for the previous owner.
  logic unused_last_owner_s;
  assign unused_last_owner_s = last_owner;
`endif

endmodule

// File: rtl/mem_arb.sv
// mem_arb: shares one single-port memory between instruction fetch (IF) and
// data access (DM). Each granted access holds mem_en for MEM_LAT cycles, then
// the owner gets a one-cycle ack with read data in its own rdata register.
// Parameters: ADDR_W (address width), DATA_W (data width), MEM_LAT (>=1
// access cycles per transfer).
// Ports:
//  clk, rst                   clock (posedge), asynchronous active-high reset
//  if_req/if_addr             fetch request and address
//  if_rdata/if_ack            fetched word and completion pulse
//  dm_req/dm_we/dm_addr/
//  dm_wdata                   data request (store when dm_we=1)
//  dm_rdata/dm_ack            load data and completion pulse
//  mem_en/mem_we/mem_addr/
//  mem_wdata/mem_rdata        memory side
//  busy                       arbiter not idle
// Build option: MEM_ARB_RR_EN selects round-robin tie breaking (see arb_pick).
module mem_arb
  import sisc_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Counter holds MEM_LAT-1 at most, one spare bit keeps it from wrapping.
  localparam int              CNT_W    = $clog2(MEM_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (MEM_LAT < 1) begin : g_bad_lat
      $error("mem_arb: MEM_LAT must be at least 1");
    end
  endgenerate

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  owner_t              owner_r;
  owner_t              last_owner_r;
  logic                mem_en_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic [DATA_W-1:0]   if_rdata_r;
  logic [DATA_W-1:0]   dm_rdata_r;
  logic                if_ack_r;
  logic                dm_ack_r;
  logic                busy_r;

  logic                grant_s;
  owner_t              owner_s;

  arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .last_owner (last_owner_r),
    .grant      (grant_s),
    .owner      (owner_s)
  );

  // Arbiter FSM: grant, count the access cycles, capture read data, ack.
  // last_owner_r only feeds the round-robin picker; in the fixed-priority
  // build nothing reads it and the flop is trimmed away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      owner_r      <= OWN_IF;
      last_owner_r <= OWN_IF;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      if_rdata_r   <= {DATA_W{1'b0}};
      dm_rdata_r   <= {DATA_W{1'b0}};
      if_ack_r     <= 1'b0;
      dm_ack_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      // Acks are single-cycle pulses; only the ACCESS exit raises one.
      if_ack_r <= 1'b0;
      dm_ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            state_r      <= ST_ACCESS;
            owner_r      <= owner_s;
            last_owner_r <= owner_s;
            cnt_r        <= CNT_LOAD;
            mem_en_r     <= 1'b1;
            busy_r       <= 1'b1;
            // Request fields are latched here so the requester may change
            // them freely while the access runs.
            if (owner_s == OWN_DM) begin
              mem_addr_r  <= dm_addr;
              mem_we_r    <= dm_we;
              mem_wdata_r <= dm_wdata;
            end else begin
              mem_addr_r  <= if_addr;
              mem_we_r    <= 1'b0;
              mem_wdata_r <= {DATA_W{1'b0}};
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            state_r  <= ST_DONE;
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
            if (owner_r == OWN_DM) begin
              dm_ack_r <= 1'b1;
              // A store leaves the previous load data in place.
              if (!mem_we_r) begin
                dm_rdata_r <= mem_rdata;
              end else begin
                dm_rdata_r <= dm_rdata_r;
              end
            end else begin
              if_ack_r   <= 1'b1;
              if_rdata_r <= mem_rdata;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_r;
  assign if_ack    = if_ack_r;
  assign dm_rdata  = dm_rdata_r;
  assign dm_ack    = dm_ack_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;

endmodule
